// File: rtl/shift_arbiter_pkg.sv
// rtl/shift_arbiter_pkg.sv - shared constants, state and op encodings for shift_arbiter
package shift_arbiter_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic OP_SLL = 1'b0;
    localparam logic OP_SRA = 1'b1;

endpackage

// File: rtl/shift_arbiter_datapath.sv
// rtl/shift_arbiter_datapath.sv - shift datapath; SHIFT_SRA_EN adds an sra unit selected by op
module shift_arbiter_datapath
    import shift_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0]  data,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               op,
    output logic [DATA_W-1:0]  result
);

    logic [DATA_W-1:0] sll_out;

    sll u_sll (
        .data     (data),
        .shiftamt (shamt),
        .out      (sll_out)
    );

`ifdef SHIFT_SRA_EN
    logic [DATA_W-1:0] sra_out;

    sra u_sra (
        .data     (data),
        .shiftamt (shamt),
        .out      (sra_out)
    );

    assign result = (op == OP_SRA) ? sra_out : sll_out;
`else
    // Without the sra unit every operation is a left shift.
    logic unused_op;
    assign unused_op = op;
    assign result    = sll_out;
`endif

endmodule

// File: rtl/sll.sv
// rtl/sll.sv - fixed-width 32-bit logical left shifter
module sll (
    input  logic [31:0] data,
    input  logic [4:0]  shiftamt,
    output logic [31:0] out
);

    assign out = data << shiftamt;

endmodule

// File: rtl/sra.sv
// rtl/sra.sv - fixed-width 32-bit arithmetic (sign-filled) right shifter
module sra (
    input  logic [31:0] data,
    input  logic [4:0]  shiftamt,
    output logic [31:0] out
);

    assign out = $signed(data) >>> shiftamt;

endmodule

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin sharing of one shift datapath between two requesters (option: SHIFT_SRA_EN)
module shift_arbiter
    import shift_arbiter_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [DATA_W-1:0]  req0_data,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic               req0_op,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [DATA_W-1:0]  req1_data,
    input  logic [SHAMT_W-1:0] req1_shamt,
    input  logic               req1_op,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_data,
    output logic               rsp_id
);

    state_t             state;
    logic               last_grant;
    logic [DATA_W-1:0]  opr_data;
    logic [SHAMT_W-1:0] opr_shamt;
    logic               opr_op;
    logic               opr_id;
    logic [DATA_W-1:0]  shift_result;

    logic grant_any;
    logic grant_id;

    // Under contention the requester that did not win last time goes next.
    assign grant_any  = (state == S_IDLE) && (req0_valid || req1_valid);
    assign grant_id   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign req0_ready = grant_any && !grant_id;
    assign req1_ready = grant_any && grant_id;
    assign rsp_valid  = (state == S_RESP);

    shift_arbiter_datapath u_datapath (
        .data   (opr_data),
        .shamt  (opr_shamt),
        .op     (opr_op),
        .result (shift_result)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            opr_data   <= '0;
            opr_shamt  <= '0;
            opr_op     <= OP_SLL;
            opr_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        opr_data   <= grant_id ? req1_data  : req0_data;
                        opr_shamt  <= grant_id ? req1_shamt : req0_shamt;
                        opr_op     <= grant_id ? req1_op    : req0_op;
                        opr_id     <= grant_id;
                        last_grant <= grant_id;
                        state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_data <= shift_result;
                    rsp_id   <= opr_id;
                    state    <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - directed self-checking bench for shift_arbiter
module tb_shift_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req0_op;
    logic [31:0] req0_data;
    logic [4:0]  req0_shamt;
    logic        req1_valid, req1_ready, req1_op;
    logic [31:0] req1_data;
    logic [4:0]  req1_shamt;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_data;

    int checks = 0;
    int errors = 0;

    shift_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_shamt (req0_shamt),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_shamt (req1_shamt),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic id, input logic v, input logic [31:0] d,
                         input logic [4:0] s, input logic op);
        if (id) begin
            req1_valid = v; req1_data = d; req1_shamt = s; req1_op = op;
        end else begin
            req0_valid = v; req0_data = d; req0_shamt = s; req0_op = op;
        end
    endtask

    // Issues one op from an IDLE cycle with rsp_ready=1 and returns in the next IDLE cycle.
    task automatic issue(input string tag, input logic id, input logic [31:0] d,
                         input logic [4:0] s, input logic op, input logic [31:0] exp);
        drive(id, 1'b1, d, s, op);
        #1;
        check({tag, "_ready"}, id ? req1_ready : req0_ready, 1);
        check({tag, "_other_ready"}, id ? req0_ready : req1_ready, 0);
        tick();
        drive(id, 1'b0, 32'h0, 5'd0, 1'b0);
        check({tag, "_exec_valid"}, rsp_valid, 0);
        check({tag, "_exec_ready"}, {req0_ready, req1_ready}, 0);
        tick();
        check({tag, "_rsp_valid"}, rsp_valid, 1);
        check({tag, "_rsp_data"}, rsp_data, exp);
        check({tag, "_rsp_id"}, rsp_id, id);
        tick();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_rsp_id"}, rsp_id, 0);
        check({tag, "_readies"}, {req0_ready, req1_ready}, 0);
    endtask

    initial begin
        reset = 1'b1;
        rsp_ready = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 5'd0, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 5'd0, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check_reset_state("reset");

        issue("single", 1'b0, 32'd300, 5'd17, 1'b0, 32'h02580000);

        // Contention straight after reset: req0 first, then req1, then alternation.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b1, 1'b1, 32'h12345678, 5'd2, 1'b0);
        issue("cont0", 1'b0, 32'hA5A5A5A5, 5'd5, 1'b0, 32'hB4B4B4A0);
        issue("cont1", 1'b1, 32'h12345678, 5'd2, 1'b0, 32'h48D159E0);
        drive(1'b1, 1'b1, 32'h00000003, 5'd1, 1'b0);
        issue("alt0", 1'b0, 32'h00000001, 5'd1, 1'b0, 32'h00000002);
        issue("alt1", 1'b1, 32'h00000003, 5'd1, 1'b0, 32'h00000006);

        // Backpressure: hold RESP for 10 cycles with req0 waiting.
        rsp_ready = 1'b0;
        drive(1'b1, 1'b1, 32'h00000001, 5'd3, 1'b0);
        #1;
        check("bp_grant", req1_ready, 1);
        tick();
        drive(1'b1, 1'b0, 32'h0, 5'd0, 1'b0);
        drive(1'b0, 1'b1, 32'hFFFFFFFF, 5'd31, 1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", rsp_valid, 1);
            check("bp_data", rsp_data, 32'h00000008);
            check("bp_no_ready", {req0_ready, req1_ready}, 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_released", rsp_valid, 0);
        issue("max_shift", 1'b0, 32'hFFFFFFFF, 5'd31, 1'b0, 32'h80000000);
        issue("zero_shift", 1'b0, 32'hDEADBEEF, 5'd0, 1'b0, 32'hDEADBEEF);

        // Reset while the op is in EXEC discards it.
        drive(1'b1, 1'b1, 32'h0000000F, 5'd4, 1'b0);
        #1;
        check("rst_exec_grant", req1_ready, 1);
        tick();
        drive(1'b1, 1'b0, 32'h0, 5'd0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("rst_exec");
        tick();
        check("rst_exec_no_rsp", rsp_valid, 0);
        drive(1'b1, 1'b1, 32'h00000005, 5'd1, 1'b0);
        issue("post_rst", 1'b0, 32'h00000007, 5'd2, 1'b0, 32'h0000001C);

        // req1 gives up before being served; nothing is started.
        drive(1'b1, 1'b0, 32'h0, 5'd0, 1'b0);
        #1;
        check("forfeit_ready", {req0_ready, req1_ready}, 0);
        tick();
        check("forfeit_idle", rsp_valid, 0);

`ifdef SHIFT_SRA_EN
        issue("sra_op", 1'b1, 32'h80000000, 5'd4, 1'b1, 32'hF8000000);
`else
        issue("sra_op", 1'b1, 32'h80000000, 5'd4, 1'b1, 32'h00000000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
